irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irqc_pkg.sv | 35 +++
 rtl/irqc_sync.sv | 53 +++++
 rtl/irq_controller.sv | 201 ++++++++++++++++++++
 tb/tb_irq_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irqc_pkg.sv
// ----------------------------------------------------------------------------
// irqc_pkg
// Shared definitions for the interrupt controller: register byte offsets,
// FSM state type, in-service ID width and a byte-mask expansion helper.
// Optional feature macro used by the controller: IRQC_EDGE_EN.
// ----------------------------------------------------------------------------
package irqc_pkg;

    // Width of an interrupt ID (0 = none, 1..31 = source index + 1).
    localparam int ID_W = 5;

    // Register byte offsets.
    localparam logic [3:0] OFF_PENDING = 4'h0;
    localparam logic [3:0] OFF_ENABLE  = 4'h4;
    localparam logic [3:0] OFF_CLAIM   = 4'h8;
    localparam logic [3:0] OFF_EDGE    = 4'hC;

    // Register select values as decoded from addr[3:2].
    localparam logic [1:0] REG_PENDING = OFF_PENDING[3:2];
    localparam logic [1:0] REG_ENABLE  = OFF_ENABLE[3:2];
    localparam logic [1:0] REG_CLAIM   = OFF_CLAIM[3:2];
    localparam logic [1:0] REG_EDGE    = OFF_EDGE[3:2];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irqc_state_e;

    // Expand a 4-bit byte mask into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/irqc_sync.sv
// ----------------------------------------------------------------------------
// irqc_sync
// One-bit two-flop synchronizer with an optional rising-edge detector.
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-low reset
//   async_i  - asynchronous input
//   sync_o   - synchronized level
//   rise_o   - one-cycle pulse on a synchronized 0->1 transition
//              (tied to 0 when EDGE_EN=0, no extra flop is built)
// ----------------------------------------------------------------------------
module irqc_sync #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_i;
            r_sync <= r_meta;
        end
    end

    assign sync_o = r_sync;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= r_sync;
                end
            end
            assign rise_o = r_sync & ~r_prev;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/irq_controller.sv
// ----------------------------------------------------------------------------
// irq_controller
// Small platform interrupt controller: NSRC synchronized sources, PENDING /
// ENABLE / CLAIM / EDGE registers on a simple chip-select bus, and a
// three-state IDLE/ASSERT/SERVICE handshake with the core.
// Optional feature: define IRQC_EDGE_EN to build the EDGE register and
// per-source edge detection; otherwise every source is level-triggered.
// Ports:
//   clk_i, reset_i   - clock, asynchronous active-low reset
//   csb_i, wen_i     - active-low chip select / write enable
//   addr_i           - byte address, [3:2] selects the register
//   data_i, wmask_i  - write data and byte write mask
//   irq_src_i        - asynchronous active-high interrupt sources
//   irq_ack_i        - one-cycle acknowledge from the core
//   meip_o           - registered interrupt request (high in ASSERT)
//   data_o           - registered read data
// ----------------------------------------------------------------------------
module irq_controller
    import irqc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            csb_i,
    input  logic            wen_i,
    input  logic [3:0]      addr_i,
    input  logic [31:0]     data_i,
    input  logic [3:0]      wmask_i,
    input  logic [NSRC-1:0] irq_src_i,
    input  logic            irq_ack_i,
    output logic            meip_o,
    output logic [31:0]     data_o
);

`ifdef IRQC_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic [NSRC-1:0] w_sync;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_wd;
    logic [NSRC-1:0] w_wbe;
    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_sel_oh;
    logic [NSRC-1:0] w_claim_oh;
    logic [NSRC-1:0] w_pend_nxt;
    logic [ID_W-1:0] w_sel_id;
    logic [ID_W-1:0] w_insvc_nxt;
    logic [31:0]     w_rdata;
    logic [31:0]     w_bmask;
    logic [1:0]      w_reg;
    logic            w_wr;
    logic            w_rd;
    logic            w_complete;
    logic            w_unused_bits;
    irqc_state_e     w_state_nxt;

    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_en;
    logic [ID_W-1:0] r_insvc;
    logic [31:0]     r_rdata;
    logic            r_meip;
    irqc_state_e     r_state;

    // Bus decode
    assign w_wr    = ~csb_i & ~wen_i;
    assign w_rd    = ~csb_i &  wen_i;
    assign w_reg   = addr_i[3:2];
    assign w_bmask = byte_mask(wmask_i);

    // Only the low NSRC bits of data/mask reach a register; the rest are dropped.
    assign w_unused_bits = ^{addr_i[1:0], data_i, w_bmask};

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_wd[gi]  = data_i[gi];
            assign w_wbe[gi] = w_bmask[gi];

            irqc_sync #(.EDGE_EN(EDGE_EN)) u_sync (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .async_i (irq_src_i[gi]),
                .sync_o  (w_sync[gi]),
                .rise_o  (w_rise[gi])
            );
        end
    endgenerate

`ifdef IRQC_EDGE_EN
    logic [NSRC-1:0] r_edge;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_edge <= '0;
        end else if (w_wr && (w_reg == REG_EDGE)) begin
            r_edge <= (r_edge & ~w_wbe) | (w_wd & w_wbe);
        end
    end

    assign w_edge = r_edge;
`else
    assign w_edge = '0;
`endif

    // Lowest pending+enabled index wins; scan high to low so the last hit is lowest.
    always_comb begin
        w_sel_id = '0;
        w_sel_oh = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (r_pend[i] && r_en[i]) begin
                w_sel_id    = ID_W'(i + 1);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    assign w_complete = w_wr && (w_reg == REG_CLAIM) && wmask_i[0] &&
                        (data_i[7:0] == 8'(r_insvc));

    always_comb begin
        w_state_nxt = r_state;
        w_insvc_nxt = r_insvc;
        w_claim_oh  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_id != '0) begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (irq_ack_i && (w_sel_id != '0)) begin
                    w_state_nxt = ST_SERVICE;
                    w_insvc_nxt = w_sel_id;
                    w_claim_oh  = w_sel_oh;
                end else if (w_sel_id == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_complete) begin
                    w_state_nxt = ST_IDLE;
                    w_insvc_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_insvc_nxt = '0;
            end
        endcase
    end

    // Level sources only accept W1C while their synchronized input is low.
    // Claim clears only edge sources. Set always wins over any clear.
    assign w_set      = (w_edge & w_rise) | (~w_edge & w_sync);
    assign w_w1c      = (w_wr && (w_reg == REG_PENDING)) ?
                        (w_wd & w_wbe & (w_edge | ~w_sync)) : '0;
    assign w_pend_nxt = w_set | (r_pend & ~(w_w1c | (w_claim_oh & w_edge)));

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_PENDING: w_rdata = 32'(r_pend);
            REG_ENABLE:  w_rdata = 32'(r_en);
            REG_CLAIM:   w_rdata = 32'(r_insvc);
            REG_EDGE:    w_rdata = 32'(w_edge);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
            r_meip  <= 1'b0;
            r_insvc <= '0;
            r_pend  <= '0;
            r_en    <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_meip  <= (w_state_nxt == ST_ASSERT);
            r_insvc <= w_insvc_nxt;
            r_pend  <= w_pend_nxt;
            if (w_wr && (w_reg == REG_ENABLE)) begin
                r_en <= (r_en & ~w_wbe) | (w_wd & w_wbe);
            end
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign meip_o = r_meip;
    assign data_o = r_rdata;

endmodule

// File: tb/tb_irq_controller.sv
// ----------------------------------------------------------------------------
// tb_irq_controller
// Directed scenarios plus a randomized run against a behavioural model of the
// interrupt controller (pending/enable/edge bit vectors, a source delay line
// and a three-phase request/service sequence).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            csb_i;
    logic            wen_i;
    logic [3:0]      addr_i;
    logic [31:0]     data_i;
    logic [3:0]      wmask_i;
    logic [NSRC-1:0] irq_src_i;
    logic            irq_ack_i;
    logic            meip_o;
    logic [31:0]     data_o;

    int checks   = 0;
    int failures = 0;

    irq_controller #(.NSRC(NSRC)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .csb_i     (csb_i),
        .wen_i     (wen_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .wmask_i   (wmask_i),
        .irq_src_i (irq_src_i),
        .irq_ack_i (irq_ack_i),
        .meip_o    (meip_o),
        .data_o    (data_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = waiting, 1 = requesting, 2 = being serviced
    logic [NSRC-1:0] m_pend, m_en, m_edge;
    logic [NSRC-1:0] m_hist [0:2];   // source samples from 1, 2, 3 edges ago
    int              m_phase;
    int              m_insvc;
    logic [31:0]     m_rdata;
    logic            m_meip;

    function automatic int pick_id(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0;
        m_hist[0] = '0; m_hist[1] = '0; m_hist[2] = '0;
        m_phase = 0; m_insvc = 0; m_rdata = '0; m_meip = 1'b0;
    endtask

    task automatic model_step();
        logic [NSRC-1:0] seen, prev, npend, nen, nedge;
        logic            wr, rd, is_edge, setb, clrb;
        int              reg_sel, sel, nphase, ninsvc;
        seen    = m_hist[1];
        prev    = m_hist[2];
        wr      = !csb_i && !wen_i;
        rd      = !csb_i &&  wen_i;
        reg_sel = int'(addr_i) / 4;
        sel     = pick_id(m_pend & m_en);
        nen     = m_en;
        nedge   = m_edge;
        nphase  = m_phase;
        ninsvc  = m_insvc;
        if (m_phase == 0 && sel != 0) nphase = 1;
        else if (m_phase == 1) begin
            if (irq_ack_i && sel != 0) begin nphase = 2; ninsvc = sel; end
            else if (sel == 0) nphase = 0;
        end else if (m_phase == 2 && wr && reg_sel == 2 && wmask_i[0] &&
                     int'(data_i[7:0]) == m_insvc) begin
            nphase = 0; ninsvc = 0;
        end
        for (int i = 0; i < NSRC; i++) begin
            is_edge = m_edge[i];
            setb = is_edge ? (seen[i] && !prev[i]) : seen[i];
            clrb = 1'b0;
            if (wr && reg_sel == 0 && data_i[i] && wmask_i[i/8] && (is_edge || !seen[i])) clrb = 1'b1;
            if (m_phase == 1 && nphase == 2 && sel == i + 1 && is_edge) clrb = 1'b1;
            npend[i] = setb || (m_pend[i] && !clrb);
            if (wr && reg_sel == 1 && wmask_i[i/8]) nen[i] = data_i[i];
`ifdef IRQC_EDGE_EN
            if (wr && reg_sel == 3 && wmask_i[i/8]) nedge[i] = data_i[i];
`endif
        end
        if (rd) begin
            case (reg_sel)
                0: m_rdata = 32'(m_pend);
                1: m_rdata = 32'(m_en);
                2: m_rdata = 32'(m_insvc);
                default: m_rdata = 32'(m_edge);
            endcase
        end
        m_pend = npend; m_en = nen; m_edge = nedge;
        m_phase = nphase; m_insvc = ninsvc;
        m_meip = (nphase == 1);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq_src_i;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        if (!reset_i) model_reset(); else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        csb_i = 1'b0; wen_i = 1'b0; addr_i = a; data_i = d; wmask_i = m;
        tick();
        csb_i = 1'b1; wen_i = 1'b1; wmask_i = 4'h0;
    endtask

    task automatic bus_rd(input logic [3:0] a);
        csb_i = 1'b0; wen_i = 1'b1; addr_i = a;
        tick();
        csb_i = 1'b1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        model_reset();
        tick();
        reset_i = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] a;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            a = 4'(r * 4);
            bus_rd(a);
            checks++;
            if (data_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_read[%0h] got=%h exp=%h", a, data_o, 32'h0);
            end
        end
        checks++;
        if (meip_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_meip got=%b exp=0", meip_o);
        end
    endtask

    task automatic test_basic();
        bus_wr(4'h4, 32'h05, 4'hF);
        irq_src_i[2] = 1'b1;
        tick();                       // edge 1 samples the rise
        irq_src_i[2] = 1'b0;
        ticks(2);                     // edge 3 sets PENDING
        checks++;
        if (meip_o !== 1'b0) begin failures++; $display("FAIL basic_meip_early got=%b exp=0", meip_o); end
        bus_rd(4'h0);                 // edge 4: reads PENDING, raises meip
        checks++;
        if (data_o !== 32'h4) begin failures++; $display("FAIL basic_pending got=%h exp=%h", data_o, 32'h4); end
        checks++;
        if (meip_o !== 1'b1) begin failures++; $display("FAIL basic_meip got=%b exp=1", meip_o); end
        irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
        checks++;
        if (meip_o !== 1'b0) begin failures++; $display("FAIL basic_meip_ack got=%b exp=0", meip_o); end
        bus_rd(4'h8);
        checks++;
        if (data_o !== 32'h3) begin failures++; $display("FAIL basic_claim got=%h exp=%h", data_o, 32'h3); end
        bus_wr(4'h8, 32'h3, 4'h1);
        checks++;
        if (meip_o !== 1'b0 || m_phase != 0) begin failures++; $display("FAIL basic_complete meip=%b phase=%0d exp=0/0", meip_o, m_phase); end
        bus_wr(4'h0, 32'h4, 4'hF);    // drop the latched level request
        ticks(2);
    endtask

    task automatic test_priority();
        bus_wr(4'h4, 32'hFFFF_FFFF, 4'hF);
        bus_rd(4'h4);
        checks++;
        if (data_o !== 32'hFF) begin failures++; $display("FAIL enable_width got=%h exp=%h", data_o, 32'hFF); end
        bus_wr(4'h4, 32'h0, 4'h0);    // masked out entirely
        bus_rd(4'h4);
        checks++;
        if (data_o !== 32'hFF) begin failures++; $display("FAIL enable_mask got=%h exp=%h", data_o, 32'hFF); end
        irq_src_i = 8'h42;
        tick();
        irq_src_i = 8'h00;
        ticks(3);
        checks++;
        if (meip_o !== 1'b1) begin failures++; $display("FAIL prio_meip got=%b exp=1", meip_o); end
        irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
        bus_rd(4'h8);
        checks++;
        if (data_o !== 32'h2) begin failures++; $display("FAIL prio_claim1 got=%h exp=%h", data_o, 32'h2); end
        bus_wr(4'h0, 32'h2, 4'hF);
        bus_wr(4'h8, 32'h2, 4'h1);
        tick();
        checks++;
        if (meip_o !== 1'b1) begin failures++; $display("FAIL prio_reassert got=%b exp=1", meip_o); end
        irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
        bus_rd(4'h8);
        checks++;
        if (data_o !== 32'h7) begin failures++; $display("FAIL prio_claim2 got=%h exp=%h", data_o, 32'h7); end
        bus_wr(4'h8, 32'h7, 4'h1);
        bus_wr(4'h0, 32'h40, 4'hF);
        ticks(2);
    endtask

    task automatic test_level_w1c();
        irq_src_i[4] = 1'b1;
        ticks(3);
        bus_wr(4'h0, 32'h10, 4'hF);
        bus_rd(4'h0);
        checks++;
        if (data_o !== 32'h10) begin failures++; $display("FAIL level_held got=%h exp=%h", data_o, 32'h10); end
        irq_src_i[4] = 1'b0;
        ticks(3);
        bus_wr(4'h0, 32'h10, 4'hF);
        bus_rd(4'h0);
        checks++;
        if (data_o !== 32'h0) begin failures++; $display("FAIL level_clear got=%h exp=%h", data_o, 32'h0); end
        tick();
        checks++;
        if (meip_o !== 1'b0) begin failures++; $display("FAIL level_meip got=%b exp=0", meip_o); end
    endtask

    task automatic test_bad_complete_reset();
        bus_wr(4'h4, 32'h05, 4'hF);
        irq_src_i[2] = 1'b1; tick(); irq_src_i[2] = 1'b0;
        ticks(3);
        irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
        bus_wr(4'h8, 32'h5, 4'h1);
        bus_rd(4'h8);
        checks++;
        if (data_o !== 32'h3) begin failures++; $display("FAIL bad_complete got=%h exp=%h", data_o, 32'h3); end
        reset_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (meip_o !== 1'b0 || data_o !== 32'h0) begin
            failures++; $display("FAIL async_reset meip=%b data=%h exp=0/0", meip_o, data_o);
        end
        tick();
        reset_i = 1'b1;
        bus_rd(4'h8);
        checks++;
        if (data_o !== 32'h0 || meip_o !== 1'b0) begin
            failures++; $display("FAIL reset_claim data=%h meip=%b exp=0/0", data_o, meip_o);
        end
    endtask

    task automatic test_edge();
`ifdef IRQC_EDGE_EN
        bus_wr(4'hC, 32'h01, 4'hF);
        irq_src_i[0] = 1'b1;
        ticks(2);
        bus_wr(4'h0, 32'h01, 4'hF);   // lands on the edge that sets bit 0
        bus_rd(4'h0);
        checks++;
        if (data_o[0] !== 1'b1) begin failures++; $display("FAIL edge_set_beats_clear got=%h exp bit0=1", data_o); end
        bus_wr(4'h0, 32'h01, 4'hF);   // edge source clears while input still high
        bus_rd(4'h0);
        checks++;
        if (data_o !== 32'h0) begin failures++; $display("FAIL edge_w1c got=%h exp=%h", data_o, 32'h0); end
        bus_rd(4'hC);
        checks++;
        if (data_o !== 32'h1) begin failures++; $display("FAIL edge_reg got=%h exp=%h", data_o, 32'h1); end
        irq_src_i[0] = 1'b0;
        ticks(3);
`else
        bus_wr(4'hC, 32'h01, 4'hF);
        bus_rd(4'hC);
        checks++;
        if (data_o !== 32'h0) begin failures++; $display("FAIL edge_absent got=%h exp=%h", data_o, 32'h0); end
`endif
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 800; c++) begin
            irq_ack_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) irq_src_i = NSRC'($urandom);
            op = int'($urandom_range(0, 11));
            csb_i = 1'b1; wen_i = 1'b1; wmask_i = 4'h0;
            addr_i = 4'($urandom); data_i = $urandom;
            case (op)
                0, 1: begin csb_i = 1'b0; wen_i = 1'b1; end
                2: begin csb_i = 1'b0; wen_i = 1'b0; addr_i = 4'h4; wmask_i = 4'($urandom); end
                3: begin csb_i = 1'b0; wen_i = 1'b0; addr_i = 4'h0; wmask_i = 4'hF; end
                4: begin csb_i = 1'b0; wen_i = 1'b0; addr_i = 4'h8; wmask_i = 4'h1; data_i = 32'(m_insvc); end
                5: begin csb_i = 1'b0; wen_i = 1'b0; addr_i = 4'h8; wmask_i = 4'($urandom); data_i = $urandom_range(0, 9); end
                6: begin csb_i = 1'b0; wen_i = 1'b0; addr_i = 4'hC; wmask_i = 4'($urandom); end
                default: ;
            endcase
            tick();
            checks++;
            if (meip_o !== m_meip) begin failures++; $display("FAIL rand_meip cyc=%0d got=%b exp=%b", c, meip_o, m_meip); end
            checks++;
            if (data_o !== m_rdata) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, data_o, m_rdata); end
        end
        csb_i = 1'b1; wen_i = 1'b1; irq_ack_i = 1'b0; irq_src_i = '0;
    endtask

    initial begin
        reset_i = 1'b0; csb_i = 1'b1; wen_i = 1'b1; addr_i = '0;
        data_i = '0; wmask_i = '0; irq_src_i = '0; irq_ack_i = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_priority();
        test_level_w1c();
        test_bad_complete_reset();
        test_edge();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
